// File: rtl/apb4_mem_slave.sv
// APB4 memory slave: base-address decode, byte strobes, PREADY wait states, PSLVERR on bad access.
// Outputs are registered; memory is held as one byte-wide array per lane so strobes map to lane enables.
module apb4_mem_slave #(
  parameter int unsigned           ADDR_WIDTH  = 32,
  parameter int unsigned           DATA_WIDTH  = 32,
  parameter int unsigned           DEPTH       = 256,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
  parameter int unsigned           WAIT_CYCLES = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [ADDR_WIDTH-1:0]   paddr,
  input  logic                    pwrite,
  input  logic                    psel,
  input  logic                    penable,
  input  logic [DATA_WIDTH-1:0]   pwdata,
  input  logic [DATA_WIDTH/8-1:0] pstrb,
  output logic [DATA_WIDTH-1:0]   prdata,
  output logic                    pready,
  output logic                    pslverr
);

  localparam int unsigned BPW      = DATA_WIDTH / 8;
  localparam int unsigned OFF_BITS = $clog2(BPW);
  localparam int unsigned IDX_W    = $clog2(DEPTH);

  localparam logic [ADDR_WIDTH:0]   MEM_BYTES  = (ADDR_WIDTH + 1)'(DEPTH * BPW);
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'(BPW - 1);
  localparam logic [3:0]            WAIT_INIT  = 4'(WAIT_CYCLES);

  typedef enum logic {
    IDLE,
    ACCESS
  } state_t;

  state_t                  state_q, state_d;
  logic [3:0]              cnt_q, cnt_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic                    write_q, write_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [BPW-1:0]          strb_q, strb_d;
  logic                    err_q, err_d;
  logic                    pready_q, pready_d;
  logic                    pslverr_q, pslverr_d;
  logic [DATA_WIDTH-1:0]   prdata_q, prdata_d;

  logic [ADDR_WIDTH-1:0]   offset;
  logic                    setup_err;
  logic [IDX_W-1:0]        setup_idx;
  logic [IDX_W-1:0]        rd_idx;
  logic [DATA_WIDTH-1:0]   rd_word;
  logic                    wr_en;

  // Decode is evaluated on the live bus but only used on the setup edge.
  always_comb begin
    offset    = paddr - BASE_ADDR;
    setup_idx = IDX_W'(offset >> OFF_BITS);
    setup_err = ({1'b0, offset} >= MEM_BYTES)
             || ((offset & ALIGN_MASK) != '0)
             || (!pwrite && (pstrb != '0));
  end

  // With zero wait states the read happens on the setup edge, before idx_q is loaded.
  assign rd_idx = (state_q == IDLE) ? setup_idx : idx_q;

  genvar gi;
  generate
    for (gi = 0; gi < BPW; gi++) begin : gen_lane
      logic [7:0] mem_lane [DEPTH];

      always_ff @(posedge clk) begin
        if (wr_en && strb_q[gi]) begin
          mem_lane[idx_q] <= wdata_q[8*gi +: 8];
        end
      end

      assign rd_word[8*gi +: 8] = mem_lane[rd_idx];
    end
  endgenerate

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    write_d   = write_q;
    wdata_d   = wdata_q;
    strb_d    = strb_q;
    err_d     = err_q;
    pready_d  = pready_q;
    pslverr_d = pslverr_q;
    prdata_d  = prdata_q;
    wr_en     = 1'b0;

    case (state_q)
      IDLE: begin
        if (psel && !penable) begin
          state_d = ACCESS;
          idx_d   = setup_idx;
          write_d = pwrite;
          wdata_d = pwdata;
          strb_d  = pstrb;
          err_d   = setup_err;
          if (WAIT_CYCLES == 0) begin
            cnt_d     = '0;
            pready_d  = 1'b1;
            pslverr_d = setup_err;
            prdata_d  = (!pwrite && !setup_err) ? rd_word : '0;
          end else begin
            cnt_d    = WAIT_INIT;
            pready_d = 1'b0;
          end
        end
      end

      ACCESS: begin
        if (!psel) begin
          // Master dropped the select mid-transfer: discard it without writing.
          state_d   = IDLE;
          cnt_d     = '0;
          pready_d  = 1'b0;
          pslverr_d = 1'b0;
          prdata_d  = '0;
        end else if (!pready_q) begin
          cnt_d = cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            pready_d  = 1'b1;
            pslverr_d = err_q;
            prdata_d  = (!write_q && !err_q) ? rd_word : '0;
          end
        end else if (penable) begin
          wr_en     = write_q && !err_q;
          state_d   = IDLE;
          pready_d  = 1'b0;
          pslverr_d = 1'b0;
          prdata_d  = '0;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      write_q   <= 1'b0;
      wdata_q   <= '0;
      strb_q    <= '0;
      err_q     <= 1'b0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      prdata_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      write_q   <= write_d;
      wdata_q   <= wdata_d;
      strb_q    <= strb_d;
      err_q     <= err_d;
      pready_q  <= pready_d;
      pslverr_q <= pslverr_d;
      prdata_q  <= prdata_d;
    end
  end

  assign prdata  = prdata_q;
  assign pready  = pready_q;
  assign pslverr = pslverr_q;

endmodule

// File: tb/tb_apb4_mem_slave.sv
// Bench for apb4_mem_slave: two instances (no-wait at base 0, 3-wait at base 0x1000) driven by
// randomized APB transfers; a monitor compares every PREADY response against a queued model result.
module tb_apb4_mem_slave;

  logic        clk;
  logic        rst_n;
  logic [31:0] paddr   [2];
  logic        pwrite  [2];
  logic        psel    [2];
  logic        penable [2];
  logic [31:0] pwdata  [2];
  logic [3:0]  pstrb   [2];
  logic [31:0] prdata  [2];
  logic        pready  [2];
  logic        pslverr [2];

  apb4_mem_slave #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH(256), .BASE_ADDR(32'h0000_0000), .WAIT_CYCLES(0)
  ) u_dut0 (
    .clk(clk), .rst_n(rst_n), .paddr(paddr[0]), .pwrite(pwrite[0]), .psel(psel[0]),
    .penable(penable[0]), .pwdata(pwdata[0]), .pstrb(pstrb[0]), .prdata(prdata[0]),
    .pready(pready[0]), .pslverr(pslverr[0])
  );

  apb4_mem_slave #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH(256), .BASE_ADDR(32'h0000_1000), .WAIT_CYCLES(3)
  ) u_dut1 (
    .clk(clk), .rst_n(rst_n), .paddr(paddr[1]), .pwrite(pwrite[1]), .psel(psel[1]),
    .penable(penable[1]), .pwdata(pwdata[1]), .pstrb(pstrb[1]), .prdata(prdata[1]),
    .pready(pready[1]), .pslverr(pslverr[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          dut;
    logic [31:0] data;
    logic        err;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  logic [31:0] ref_mem [2][256];
  int          checks = 0;
  int          passes = 0;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endfunction

  function automatic logic [31:0] base_of(input int d);
    return (d == 0) ? 32'h0000_0000 : 32'h0000_1000;
  endfunction

  function automatic int wait_of(input int d);
    return (d == 0) ? 0 : 3;
  endfunction

  // Reference: a word-array memory seen through the address/strobe rules of the slave.
  function automatic void model(input int d, input logic [31:0] addr, input logic wr,
                                input logic [31:0] wd, input logic [3:0] st, input bit commit,
                                output logic [31:0] rdata, output logic err);
    logic [31:0] off;
    int          word;
    off   = addr - base_of(d);
    err   = (off >= 32'd1024) || (addr[1:0] != 2'b00) || (!wr && st != 4'h0);
    rdata = 32'h0;
    word  = int'(off >> 2);
    if (!err) begin
      if (wr) begin
        if (commit)
          for (int b = 0; b < 4; b++)
            if (st[b]) ref_mem[d][word][8*b +: 8] = wd[8*b +: 8];
      end else begin
        rdata = ref_mem[d][word];
      end
    end
  endfunction

  // Called just after a rising edge; returns just after the completion edge with the bus idle.
  task automatic apb_xfer(input int d, input logic [31:0] addr, input logic wr,
                          input logic [31:0] wd, input logic [3:0] st, output int cycles);
    logic [31:0] r;
    logic        e;
    model(d, addr, wr, wd, st, 1'b1, r, e);
    exp_q.push_back('{d, r, e});
    psel[d] = 1'b1; penable[d] = 1'b0;
    paddr[d] = addr; pwrite[d] = wr; pwdata[d] = wd; pstrb[d] = st;
    @(posedge clk); #1;
    penable[d] = 1'b1;
    // The slave must ignore bus changes once the setup phase is sampled.
    paddr[d] = $urandom; pwdata[d] = $urandom; pstrb[d] = 4'($urandom); pwrite[d] = 1'($urandom);
    cycles = 1;
    forever begin
      @(negedge clk);
      cycles++;
      if (pready[d]) break;
      if (cycles > 40) begin
        checks++;
        $display("FAIL pready_timeout dut%0d: got no pready, expected one within 40 cycles", d);
        break;
      end
    end
    @(posedge clk); #1;
    psel[d] = 1'b0; penable[d] = 1'b0;
    check($sformatf("latency_dut%0d", d), 32'(cycles), 32'(wait_of(d) + 2));
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: every cycle with pready consumes one queued response; idle cycles must show zeros.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int d = 0; d < 2; d++) begin
        if (pready[d]) begin
          if (exp_q.size() == 0 || exp_q[0].dut != d) begin
            checks++;
            $display("FAIL unexpected_pready dut%0d: got pready=1, expected no response", d);
          end else begin
            mon_e = exp_q.pop_front();
            $display("dut%0d resp prdata=0x%08h pslverr=%0b", d, prdata[d], pslverr[d]);
            check($sformatf("prdata_dut%0d", d), prdata[d], mon_e.data);
            check($sformatf("pslverr_dut%0d", d), 32'(pslverr[d]), 32'(mon_e.err));
          end
        end else begin
          check($sformatf("idle_prdata_dut%0d", d), prdata[d], 32'h0);
          check($sformatf("idle_pslverr_dut%0d", d), 32'(pslverr[d]), 32'h0);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no end of test, expected finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int          cyc;
    int          total;
    int          d;
    int          kind;
    logic [31:0] a;
    logic [31:0] r;
    logic        e;
    logic        w;
    logic [3:0]  s;

    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      psel[i] = 1'b0; penable[i] = 1'b0; paddr[i] = '0; pwrite[i] = 1'b0;
      pwdata[i] = '0; pstrb[i] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      check("reset_pready", 32'(pready[i]), 32'h0);
      check("reset_pslverr", 32'(pslverr[i]), 32'h0);
      check("reset_prdata", prdata[i], 32'h0);
    end
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // Fill both memories so every later read has a defined reference value.
    for (int i = 0; i < 2; i++)
      for (int wi = 0; wi < 256; wi++)
        apb_xfer(i, base_of(i) + 32'(wi * 4), 1'b1, $urandom, 4'hF, cyc);

    // Reset in the access phase of a write to 0x8 on the no-wait slave.
    model(0, 32'h8, 1'b1, 32'hDEAD_BEEF, 4'hF, 1'b0, r, e);
    exp_q.push_back('{0, r, e});
    psel[0] = 1'b1; penable[0] = 1'b0; paddr[0] = 32'h8; pwrite[0] = 1'b1;
    pwdata[0] = 32'hDEAD_BEEF; pstrb[0] = 4'hF;
    @(posedge clk); #1;
    penable[0] = 1'b1;
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      check("async_reset_pready", 32'(pready[i]), 32'h0);
      check("async_reset_pslverr", 32'(pslverr[i]), 32'h0);
      check("async_reset_prdata", prdata[i], 32'h0);
    end
    psel[0] = 1'b0; penable[0] = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    apb_xfer(0, 32'h8, 1'b0, 32'h0, 4'h0, cyc);

    // Simple write/read and byte strobes on the no-wait slave.
    apb_xfer(0, 32'h8, 1'b1, 32'h0000_0016, 4'hF, cyc);
    apb_xfer(0, 32'h8, 1'b0, 32'h0, 4'h0, cyc);
    apb_xfer(0, 32'h10, 1'b1, 32'hAABB_CCDD, 4'hF, cyc);
    apb_xfer(0, 32'h10, 1'b1, 32'h1122_3344, 4'b0101, cyc);
    apb_xfer(0, 32'h10, 1'b0, 32'h0, 4'h0, cyc);
    apb_xfer(0, 32'h10, 1'b1, 32'h5555_5555, 4'h0, cyc);
    apb_xfer(0, 32'h10, 1'b0, 32'h0, 4'h0, cyc);

    // Wait states and error responses on the base-0x1000 slave.
    apb_xfer(1, 32'h1004, 1'b0, 32'h0, 4'h0, cyc);
    apb_xfer(1, 32'h1400, 1'b1, 32'hFFFF_FFFF, 4'hF, cyc);
    apb_xfer(1, 32'h1002, 1'b1, 32'hFFFF_FFFF, 4'hF, cyc);
    apb_xfer(1, 32'h1000, 1'b0, 32'h0, 4'h1, cyc);
    apb_xfer(1, 32'h0FFC, 1'b1, 32'hFFFF_FFFF, 4'hF, cyc);
    apb_xfer(1, 32'h1000, 1'b0, 32'h0, 4'h0, cyc);
    apb_xfer(1, 32'h13FC, 1'b0, 32'h0, 4'h0, cyc);

    // Three back-to-back writes, then a read-back of each.
    total = 0;
    for (int i = 0; i < 3; i++) begin
      apb_xfer(0, 32'h20 + 32'(i * 4), 1'b1, $urandom, 4'hF, cyc);
      total += cyc;
    end
    check("back_to_back_cycles", 32'(total), 32'd6);
    for (int i = 0; i < 3; i++) apb_xfer(0, 32'h20 + 32'(i * 4), 1'b0, 32'h0, 4'h0, cyc);

    // Abort: select dropped during the access phase of a write.
    psel[1] = 1'b1; penable[1] = 1'b0; paddr[1] = 32'h1040; pwrite[1] = 1'b1;
    pwdata[1] = 32'hCAFE_F00D; pstrb[1] = 4'hF;
    @(posedge clk); #1;
    penable[1] = 1'b1;
    @(posedge clk); #1;
    psel[1] = 1'b0; penable[1] = 1'b0;
    repeat (4) begin
      @(negedge clk);
      check("abort_pready", 32'(pready[1]), 32'h0);
    end
    @(posedge clk); #1;
    apb_xfer(1, 32'h1040, 1'b0, 32'h0, 4'h0, cyc);

    // Randomized mix of legal and illegal transfers on both slaves.
    for (int n = 0; n < 300; n++) begin
      d    = int'($urandom_range(0, 1));
      kind = int'($urandom_range(0, 9));
      case (kind)
        0:       a = base_of(d) + 32'($urandom_range(0, 255) * 4) + 32'($urandom_range(1, 3));
        1:       a = base_of(d) + 32'd1024 + 32'($urandom_range(0, 255) * 4);
        2:       a = $urandom;
        default: a = base_of(d) + 32'($urandom_range(0, 255) * 4);
      endcase
      w = 1'($urandom);
      s = 4'($urandom);
      if (!w && ($urandom_range(0, 7) != 0)) s = 4'h0;
      apb_xfer(d, a, w, $urandom, s, cyc);
      if ($urandom_range(0, 2) != 0) idle(int'($urandom_range(1, 2)));
    end

    idle(3);
    check("scoreboard_drained", 32'(exp_q.size()), 32'h0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
